interleaver_ctrl: RTL and testbench
===================================

// Module: interleaver_ctrl
// PURPOSE
//  Symbol-level sequencer for the TX interleaver. Decodes the 802.11a RATE field into N_BPSC/N_CBPS.
//  Gates coded bit pairs from the convolutional encoder into the interleaver, one OFDM symbol at a time.
//  Waits for the interleaver's ready, then hands each interleaved symbol to the mapper.
//  Sits between encoder output and mapper input.
// PARAMETERS
//  MAX_SYM      4095  largest symbol count per frame (sets n_sym width, 12 b)
//  TIMEOUT_CYC  64    max cycles in WAIT_RDY before error
// PORTS
//  Clk          in   1   single clock, rising edge
//  Rst_n        in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse; latches rate, n_sym; honoured only in IDLE
//  abort        in   1   synchronous abort; returns to IDLE next cycle
//  rate         in   4   802.11a RATE code
//  n_sym        in   12  OFDM symbols in frame
//  src_valid    in   1   encoder pair valid
//  src_data     in   2   coded bit pair, [0] first in time
//  src_ready    out  1   controller accepts pair
//  il_en        out  1   interleaver write enable (one pair per cycle)
//  il_data      out  2   pair to interleaver
//  il_ready     in   1   interleaver symbol complete
//  n_bpsc       out  3   1/2/4/6 to interleaver and mapper
//  n_cbps       out  9   48/96/192/288
//  out_valid    out  1   interleaved symbol available to mapper
//  out_ready    in   1   mapper accepts symbol
//  busy         out  1   state != IDLE
//  done         out  1   1-cycle pulse after last symbol handed off
//  err          out  1   sticky error; cleared by next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0 except n_bpsc=1, n_cbps=48. Counters 0.
//  - Rate table: 1101/1111→BPSK,48; 0101/0111→QPSK,96; 1001/1011→16QAM,192; 0001/0011→64QAM,288.
//    Latched at start; held until next start.
//  - FSM: IDLE→(start) CFG→FILL→WAIT_RDY→HANDOFF→FILL | FIN→IDLE.
//  - CFG: 1 cycle. Loads table outputs and pair_cnt=0, sym_cnt=0. n_sym==0 → FIN directly.
//  - FILL: src_ready=1. Combinational il_en = src_valid & src_ready; il_data=src_data.
//    Zero added latency. pair_cnt increments per transfer.
//    On the transfer with pair_cnt==N_CBPS/2-1 → WAIT_RDY, pair_cnt←0.
//  - WAIT_RDY: src_ready=0, il_en=0. On il_ready → HANDOFF. Timer counts cycles here.
//    Reaching TIMEOUT_CYC sets err → IDLE.
//  - HANDOFF: out_valid=1 and held stable until out_ready (valid/ready; no drop).
//    On accept: sym_cnt++. If sym_cnt+1==n_sym → FIN, else → FILL.
//  - FIN: done=1 for one cycle → IDLE.
//  - Simultaneous out_ready and last symbol: done asserts the following cycle.
//    No early start of the next frame.
//  - abort has priority over all transitions: src_ready, il_en, out_valid drop the next cycle; no done.
//  - start while busy: ignored, no error. Rst_n mid-frame: immediate return to reset values.
//  - Counters: pair_cnt 8 b, sym_cnt 12 b, timer clog2(TIMEOUT_CYC+1) b.
//    No wrap: terminal compares are exact.
// CONFIGURATION
//  - ILV_RATE_CHECK_EN defined: a rate code outside the table at start sets err, FSM stays IDLE,
//    busy stays 0.
//  - Undefined: an invalid code maps to BPSK/48 (6 Mb/s) and the frame runs normally; err only from timeout.
// STRUCTURE
//  - Package ilv_pkg: rate code localparams (RATE_6M..RATE_54M), state encoding, function rate_to_cbps/bpsc.
//  - Sub-module ilv_rate_lut: combinational rate→{n_bpsc,n_cbps,valid}; shared later with the mapper ctrl.
// TESTING
//  1. rate=1101, n_sym=2, src_valid=1, il_ready 3 cycles after 24th pair, out_ready=1
//     → 24 il_en per symbol; done once; 48 pairs total.
//  2. rate=0011, n_sym=1 → n_cbps=288, n_bpsc=6, exactly 144 il_en before WAIT_RDY.
//  3. rate=0101, out_ready low 5 cycles in HANDOFF → out_valid held 6 cycles; src_ready=0 throughout.
//  4. il_ready never asserted, TIMEOUT_CYC=64 → err=1 at cycle 64 of WAIT_RDY; IDLE; next start clears err.
//  5. abort at pair 10 of symbol 1 → src_ready/il_en 0 next cycle; busy 0; no done.
//     Restart works; a Rst_n low mid-frame gives the same result.
//  6. rate=0000 → with ILV_RATE_CHECK_EN: err=1, busy never 1; without: frame runs as 48 CBPS.

Source files
------------

// File: rtl/ilv_pkg.sv
// ---------------------------------------------------------------------------
// ilv_pkg
// Shared definitions for the TX interleaver controller and its rate LUT:
//   - 802.11a RATE field codes (RATE_6M .. RATE_54M)
//   - per-modulation N_BPSC / N_CBPS constants
//   - controller state encoding
//   - rate decode helper functions (invalid codes decode to 0 / not valid)
// ---------------------------------------------------------------------------
package ilv_pkg;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    localparam logic [2:0] BPSC_BPSK  = 3'd1;
    localparam logic [2:0] BPSC_QPSK  = 3'd2;
    localparam logic [2:0] BPSC_16QAM = 3'd4;
    localparam logic [2:0] BPSC_64QAM = 3'd6;

    localparam logic [8:0] CBPS_BPSK  = 9'd48;
    localparam logic [8:0] CBPS_QPSK  = 9'd96;
    localparam logic [8:0] CBPS_16QAM = 9'd192;
    localparam logic [8:0] CBPS_64QAM = 9'd288;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG      = 3'd1,
        ST_FILL     = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_HANDOFF  = 3'd4,
        ST_FIN      = 3'd5
    } ilv_state_e;

    function automatic logic [2:0] rate_to_bpsc(input logic [3:0] rate);
        case (rate)
            RATE_6M,  RATE_9M:  rate_to_bpsc = BPSC_BPSK;
            RATE_12M, RATE_18M: rate_to_bpsc = BPSC_QPSK;
            RATE_24M, RATE_36M: rate_to_bpsc = BPSC_16QAM;
            RATE_48M, RATE_54M: rate_to_bpsc = BPSC_64QAM;
            default:            rate_to_bpsc = 3'd0;
        endcase
    endfunction

    function automatic logic [8:0] rate_to_cbps(input logic [3:0] rate);
        case (rate)
            RATE_6M,  RATE_9M:  rate_to_cbps = CBPS_BPSK;
            RATE_12M, RATE_18M: rate_to_cbps = CBPS_QPSK;
            RATE_24M, RATE_36M: rate_to_cbps = CBPS_16QAM;
            RATE_48M, RATE_54M: rate_to_cbps = CBPS_64QAM;
            default:            rate_to_cbps = 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/ilv_rate_lut.sv
// ---------------------------------------------------------------------------
// ilv_rate_lut
// Combinational 802.11a RATE decode. Unknown codes give o_valid=0 and zero
// N_BPSC/N_CBPS; the consumer decides how to treat them.
// Ports:
//   i_rate    [3:0]  RATE field code
//   o_n_bpsc  [2:0]  coded bits per subcarrier (1/2/4/6)
//   o_n_cbps  [8:0]  coded bits per OFDM symbol (48/96/192/288)
//   o_valid          code is one of the eight defined rates
// ---------------------------------------------------------------------------
module ilv_rate_lut
    import ilv_pkg::*;
(
    input  logic [3:0] i_rate,
    output logic [2:0] o_n_bpsc,
    output logic [8:0] o_n_cbps,
    output logic       o_valid
);

    // Table decode; a defined code always has a non-zero N_CBPS.
    always_comb begin
        o_n_bpsc = rate_to_bpsc(i_rate);
        o_n_cbps = rate_to_cbps(i_rate);
        o_valid  = (o_n_cbps != 9'd0);
    end

endmodule

// File: rtl/interleaver_ctrl.sv
// ---------------------------------------------------------------------------
// interleaver_ctrl
// Symbol-level sequencer between the convolutional encoder and the mapper.
// Latches RATE/N_SYM at start, gates N_CBPS/2 coded pairs per symbol into the
// interleaver, waits (bounded) for the interleaver to finish the symbol, then
// hands it to the mapper over a valid/ready handshake.
// Build option: ILV_RATE_CHECK_EN -- reject undefined RATE codes at start
// (err set, stays idle). Without it undefined codes run as BPSK/48.
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_start, i_abort             frame start pulse (IDLE only), sync abort
//   i_rate, i_n_sym              frame configuration
//   i_src_valid/i_src_data/o_src_ready  encoder pair stream
//   o_il_en, o_il_data, i_il_ready      interleaver write side / symbol done
//   o_n_bpsc, o_n_cbps           latched modulation parameters
//   o_out_valid, i_out_ready     symbol handoff to mapper
//   o_busy, o_done, o_err        status (err is sticky)
// ---------------------------------------------------------------------------
module interleaver_ctrl
    import ilv_pkg::*;
#(
    parameter int MAX_SYM     = 4095,
    parameter int TIMEOUT_CYC = 64,
    parameter int SYM_W       = $clog2(MAX_SYM + 1)
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [3:0]       i_rate,
    input  logic [SYM_W-1:0] i_n_sym,
    input  logic             i_src_valid,
    input  logic [1:0]       i_src_data,
    output logic             o_src_ready,
    output logic             o_il_en,
    output logic [1:0]       o_il_data,
    input  logic             i_il_ready,
    output logic [2:0]       o_n_bpsc,
    output logic [8:0]       o_n_cbps,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int              TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    ilv_state_e       r_state;
    ilv_state_e       w_next_state;
    logic [2:0]       r_n_bpsc;
    logic [8:0]       r_n_cbps;
    logic [SYM_W-1:0] r_n_sym;
    logic [7:0]       r_pair_cnt;
    logic [SYM_W-1:0] r_sym_cnt;
    logic [TMR_W-1:0] r_timer;
    logic             r_err;

    logic [2:0]       w_lut_bpsc;
    logic [8:0]       w_lut_cbps;
    logic             w_rate_valid;
    logic [2:0]       w_cfg_bpsc;
    logic [8:0]       w_cfg_cbps;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_xfer;
    logic             w_pair_last;
    logic             w_sym_last;
    logic             w_timeout;

    ilv_rate_lut u_rate_lut (
        .i_rate   (i_rate),
        .o_n_bpsc (w_lut_bpsc),
        .o_n_cbps (w_lut_cbps),
        .o_valid  (w_rate_valid)
    );

    // Undefined codes fall back to the 6 Mb/s (BPSK/48) configuration.
    assign w_cfg_bpsc = w_rate_valid ? w_lut_bpsc : BPSC_BPSK;
    assign w_cfg_cbps = w_rate_valid ? w_lut_cbps : CBPS_BPSK;

`ifdef ILV_RATE_CHECK_EN
    assign w_start_ok  = i_start &  w_rate_valid;
    assign w_start_bad = i_start & ~w_rate_valid;
`else
    assign w_start_ok  = i_start;
    assign w_start_bad = 1'b0;
`endif

    assign w_xfer      = (r_state == ST_FILL) & i_src_valid;
    assign w_pair_last = (r_pair_cnt == (r_n_cbps[8:1] - 8'd1));
    assign w_sym_last  = ((r_sym_cnt + SYM_W'(1)) == r_n_sym);
    assign w_timeout   = (r_timer == TMR_LAST);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        w_next_state = r_state;
        if (i_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_next_state = w_start_ok ? ST_CFG : ST_IDLE;
                ST_CFG:      w_next_state = (r_n_sym == '0) ? ST_FIN : ST_FILL;
                ST_FILL:     w_next_state = (w_xfer && w_pair_last) ? ST_WAIT_RDY : ST_FILL;
                ST_WAIT_RDY: begin
                    if (i_il_ready) begin
                        w_next_state = ST_HANDOFF;
                    end else if (w_timeout) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_WAIT_RDY;
                    end
                end
                ST_HANDOFF: begin
                    if (i_out_ready) begin
                        w_next_state = w_sym_last ? ST_FIN : ST_FILL;
                    end else begin
                        w_next_state = ST_HANDOFF;
                    end
                end
                ST_FIN:      w_next_state = ST_IDLE;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    // Configuration, counters and sticky error; frozen while abort is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n_bpsc   <= BPSC_BPSK;
            r_n_cbps   <= CBPS_BPSK;
            r_n_sym    <= '0;
            r_pair_cnt <= 8'd0;
            r_sym_cnt  <= '0;
            r_timer    <= '0;
            r_err      <= 1'b0;
        end else if (!i_abort) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_n_bpsc <= w_cfg_bpsc;
                        r_n_cbps <= w_cfg_cbps;
                        r_n_sym  <= i_n_sym;
                        r_err    <= 1'b0;
                    end else if (w_start_bad) begin
                        r_err    <= 1'b1;
                    end
                end
                ST_CFG: begin
                    r_pair_cnt <= 8'd0;
                    r_sym_cnt  <= '0;
                    r_timer    <= '0;
                end
                ST_FILL: begin
                    if (w_xfer) begin
                        if (w_pair_last) begin
                            r_pair_cnt <= 8'd0;
                            r_timer    <= '0;
                        end else begin
                            r_pair_cnt <= r_pair_cnt + 8'd1;
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (!i_il_ready) begin
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                end
                ST_HANDOFF: begin
                    if (i_out_ready) begin
                        r_sym_cnt <= r_sym_cnt + SYM_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; the pair path is combinational so FILL adds no latency.
    always_comb begin
        o_src_ready = 1'b0;
        o_out_valid = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_FILL:    o_src_ready = 1'b1;
            ST_HANDOFF: o_out_valid = 1'b1;
            ST_FIN:     o_done      = 1'b1;
            default: begin
            end
        endcase
        o_il_en   = i_src_valid & o_src_ready;
        o_il_data = o_src_ready ? i_src_data : 2'b00;
        o_busy    = (r_state != ST_IDLE);
        o_n_bpsc  = r_n_bpsc;
        o_n_cbps  = r_n_cbps;
        o_err     = r_err;
    end

endmodule

// File: tb/tb_interleaver_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interleaver_ctrl
// Directed bench for interleaver_ctrl. Inputs are driven and outputs sampled
// on the falling edge; the DUT registers on the rising edge.
// ---------------------------------------------------------------------------
module tb_interleaver_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_abort;
    logic [3:0]  i_rate;
    logic [11:0] i_n_sym;
    logic        i_src_valid;
    logic [1:0]  i_src_data;
    logic        o_src_ready;
    logic        o_il_en;
    logic [1:0]  o_il_data;
    logic        i_il_ready;
    logic [2:0]  o_n_bpsc;
    logic [8:0]  o_n_cbps;
    logic        o_out_valid;
    logic        i_out_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    interleaver_ctrl #(.MAX_SYM(4095), .TIMEOUT_CYC(64)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_rate      (i_rate),
        .i_n_sym     (i_n_sym),
        .i_src_valid (i_src_valid),
        .i_src_data  (i_src_data),
        .o_src_ready (o_src_ready),
        .o_il_en     (o_il_en),
        .o_il_data   (o_il_data),
        .i_il_ready  (i_il_ready),
        .o_n_bpsc    (o_n_bpsc),
        .o_n_cbps    (o_n_cbps),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Counts done pulses as the DUT clocks them.
    always @(posedge i_clk) begin
        if (o_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_start(input logic [3:0] rate, input logic [11:0] nsym);
        i_rate  = rate;
        i_n_sym = nsym;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Offers pairs until the DUT leaves FILL; returns number of il_en cycles.
    task automatic run_fill(output int pairs);
        pairs       = 0;
        i_src_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            i_src_data = 2'(c);
            #1;
            if (!o_src_ready) break;
            if (o_il_en) pairs++;
            tick();
        end
        i_src_valid = 1'b0;
    endtask

    // Interleaver reports symbol complete after 'delay' idle cycles.
    task automatic wait_rdy(input int delay);
        for (int c = 0; c < delay; c++) tick();
        i_il_ready = 1'b1;
        tick();
        i_il_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pairs;
        int total;
        int base;
        int cnt;
        int bad;

        i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_rate = 4'd0;
        i_n_sym = 12'd0; i_src_valid = 1'b0; i_src_data = 2'd0;
        i_il_ready = 1'b0; i_out_ready = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();

        // Reset state
        i_src_valid = 1'b1;
        #1;
        chk("rst_bpsc", int'(o_n_bpsc), 1);
        chk("rst_cbps", int'(o_n_cbps), 48);
        chk("rst_src_ready", int'(o_src_ready), 0);
        chk("rst_il_en", int'(o_il_en), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_out_valid", int'(o_out_valid), 0);
        i_src_valid = 1'b0;

        // 1: 6 Mb/s, two symbols
        base = done_cnt;
        do_start(4'b1101, 12'd2);
        chk("t1_busy_cfg", int'(o_busy), 1);
        tick();
        i_src_valid = 1'b1;
        i_src_data  = 2'b10;
        #1;
        chk("t1_il_en_comb", int'(o_il_en), 1);
        chk("t1_il_data", int'(o_il_data), 2);
        run_fill(pairs);
        chk("t1_sym0_pairs", pairs, 24);
        total = pairs;
        chk("t1_wait_no_ovalid", int'(o_out_valid), 0);
        wait_rdy(3);
        chk("t1_handoff_valid", int'(o_out_valid), 1);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        chk("t1_no_done_mid", int'(o_done), 0);
        run_fill(pairs);
        chk("t1_sym1_pairs", pairs, 24);
        total += pairs;
        wait_rdy(3);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        chk("t1_done", int'(o_done), 1);
        tick();
        chk("t1_done_pulse", int'(o_done), 0);
        chk("t1_idle", int'(o_busy), 0);
        chk("t1_total_pairs", total, 48);
        chk("t1_done_count", done_cnt - base, 1);

        // 2: 54 Mb/s, one symbol
        base = done_cnt;
        do_start(4'b0011, 12'd1);
        tick();
        chk("t2_cbps", int'(o_n_cbps), 288);
        chk("t2_bpsc", int'(o_n_bpsc), 6);
        run_fill(pairs);
        chk("t2_pairs", pairs, 144);
        i_src_valid = 1'b1;
        #1;
        chk("t2_wait_il_en", int'(o_il_en), 0);
        i_src_valid = 1'b0;
        wait_rdy(1);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        chk("t2_done", int'(o_done), 1);
        tick();
        chk("t2_done_count", done_cnt - base, 1);

        // 3: 12 Mb/s, mapper back-pressure; start while busy is ignored
        do_start(4'b0101, 12'd1);
        tick();
        chk("t3_cbps", int'(o_n_cbps), 96);
        run_fill(pairs);
        chk("t3_pairs", pairs, 48);
        wait_rdy(0);
        cnt = 0;
        bad = 0;
        i_src_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            i_start = (c == 2);
            i_rate  = 4'b0011;
            i_n_sym = 12'd5;
            #1;
            if (o_out_valid) cnt++;
            if (o_src_ready || o_il_en) bad++;
            tick();
        end
        i_start     = 1'b0;
        i_out_ready = 1'b1;
        #1;
        if (o_out_valid) cnt++;
        if (o_src_ready || o_il_en) bad++;
        tick();
        i_out_ready = 1'b0;
        i_src_valid = 1'b0;
        chk("t3_ovalid_cycles", cnt, 6);
        chk("t3_src_ready_low", bad, 0);
        chk("t3_cbps_held", int'(o_n_cbps), 96);
        chk("t3_done", int'(o_done), 1);
        chk("t3_err", int'(o_err), 0);
        tick();
        chk("t3_idle", int'(o_busy), 0);

        // 4: interleaver never ready -> timeout
        do_start(4'b1101, 12'd1);
        tick();
        run_fill(pairs);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!o_busy) break;
            cnt++;
            tick();
        end
        chk("t4_wait_cycles", cnt, 64);
        chk("t4_err", int'(o_err), 1);
        chk("t4_idle", int'(o_busy), 0);
        base = done_cnt;
        do_start(4'b1101, 12'd0);
        chk("t4_err_cleared", int'(o_err), 0);
        chk("t4_busy", int'(o_busy), 1);
        tick();
        chk("t4_nsym0_done", int'(o_done), 1);
        tick();
        chk("t4_done_count", done_cnt - base, 1);

        // 5: abort at pair 10 of symbol 1, restart, then reset mid-frame
        base = done_cnt;
        do_start(4'b1101, 12'd2);
        tick();
        run_fill(pairs);
        wait_rdy(1);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        i_src_valid = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (o_il_en) cnt++;
            tick();
        end
        chk("t5_pairs_before_abort", cnt, 10);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        #1;
        chk("t5_src_ready", int'(o_src_ready), 0);
        chk("t5_il_en", int'(o_il_en), 0);
        chk("t5_busy", int'(o_busy), 0);
        i_src_valid = 1'b0;
        tick();
        tick();
        chk("t5_no_done", done_cnt - base, 0);
        do_start(4'b1101, 12'd1);
        tick();
        run_fill(pairs);
        chk("t5_restart_pairs", pairs, 24);
        wait_rdy(2);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        tick();
        chk("t5_restart_done", done_cnt - base, 1);
        do_start(4'b0011, 12'd3);
        tick();
        i_src_valid = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        i_rst_n = 1'b0;
        #1;
        chk("t5_rst_src_ready", int'(o_src_ready), 0);
        chk("t5_rst_il_en", int'(o_il_en), 0);
        chk("t5_rst_busy", int'(o_busy), 0);
        chk("t5_rst_cbps", int'(o_n_cbps), 48);
        chk("t5_rst_bpsc", int'(o_n_bpsc), 1);
        i_src_valid = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("t5_rst_idle", int'(o_busy), 0);

        // 6: undefined rate code
        base = done_cnt;
`ifdef ILV_RATE_CHECK_EN
        do_start(4'b0000, 12'd1);
        chk("t6_err", int'(o_err), 1);
        chk("t6_busy", int'(o_busy), 0);
        tick();
        chk("t6_busy_still", int'(o_busy), 0);
        chk("t6_no_done", done_cnt - base, 0);
`else
        do_start(4'b0000, 12'd1);
        chk("t6_busy", int'(o_busy), 1);
        tick();
        chk("t6_cbps", int'(o_n_cbps), 48);
        chk("t6_bpsc", int'(o_n_bpsc), 1);
        run_fill(pairs);
        chk("t6_pairs", pairs, 24);
        wait_rdy(1);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        tick();
        chk("t6_done", done_cnt - base, 1);
        chk("t6_err", int'(o_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
